channel_vector_sequencer: RTL

- Parametrised successor to the combinational channel-vector lookup.
- On a start command, walks a channel counter through NUM_CHANNELS steps, one channel per handshake beat.
- For each of NUM_MODS modalities, retrieves the item-memory (iM), projM_pos and projM_neg hypervectors for that channel and presents them registered on a valid/ready stream.
- Sits between the HD encoder control FSM and the spatial encoder/bundler.
- Per-modality channel base offsets with wrap-around allow each modality to start at a different channel.

---
 rtl/channel_vector_sequencer_pkg.sv | 51 +++++
 rtl/channel_vector_sequencer_row_select.sv | 35 +++
 rtl/channel_vector_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/channel_vector_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// channel_vector_sequencer_pkg
// Shared definitions for the channel vector sequencer:
//   - HV_DIMENSION / INPUT_CHANNELS default geometry
//   - ceil_log2 helper for index widths
//   - iM / projM_pos / projM_neg tables and their *_WIDTH
//   - FSM state encoding (IDLE=0, RUN=1)
//   - rotr: cyclic right rotation used when CHANNEL_VECTORS_ROTATE_EN is
//     defined (tables then only contribute their row 0 as a seed)
// -----------------------------------------------------------------------------
package channel_vector_sequencer_pkg;

  localparam int HV_DIMENSION   = 16;
  localparam int INPUT_CHANNELS = 4;

  // Minimum result of 1 keeps a single-channel configuration from
  // producing a zero-width index.
  function automatic int ceil_log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  localparam int IM_WIDTH        = HV_DIMENSION;
  localparam int PROJM_POS_WIDTH = HV_DIMENSION;
  localparam int PROJM_NEG_WIDTH = HV_DIMENSION;

  localparam logic [IM_WIDTH-1:0] IM_TABLE [INPUT_CHANNELS] =
    '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  localparam logic [PROJM_POS_WIDTH-1:0] PROJM_POS_TABLE [INPUT_CHANNELS] =
    '{16'h11EE, 16'h22DD, 16'h33CC, 16'h44BB};
  localparam logic [PROJM_NEG_WIDTH-1:0] PROJM_NEG_TABLE [INPUT_CHANNELS] =
    '{16'hEE11, 16'hDD22, 16'hCC33, 16'hBB44};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Rotate right by r (r < HV_DIMENSION): bit i of the result is v[(i+r) mod W].
  function automatic logic [HV_DIMENSION-1:0] rotr(
    input logic [HV_DIMENSION-1:0] v,
    input int unsigned             r
  );
    logic [2*HV_DIMENSION-1:0] d;
    d = {v, v} >> r;
    return d[HV_DIMENSION-1:0];
  endfunction

endpackage

// File: rtl/channel_vector_sequencer_row_select.sv
// -----------------------------------------------------------------------------
// channel_vector_row_select
// Combinational row fetch for one modality: given a row index, returns the
// iM, projM_pos and projM_neg hypervectors of that row.
// Build option CHANNEL_VECTORS_ROTATE_EN: instead of a table lookup, the
// row-0 seed of each table is rotated right by the row index.
// Ports:
//   row_i  in  CH_W   row index (already reduced modulo NUM_CHANNELS)
//   im_o   out WIDTH  item-memory vector
//   pos_o  out WIDTH  positive projection vector
//   neg_o  out WIDTH  negative projection vector
// -----------------------------------------------------------------------------
module channel_vector_row_select
  import channel_vector_sequencer_pkg::*;
#(
  parameter int WIDTH = HV_DIMENSION,
  parameter int CH_W  = 2
) (
  input  logic [CH_W-1:0]  row_i,
  output logic [WIDTH-1:0] im_o,
  output logic [WIDTH-1:0] pos_o,
  output logic [WIDTH-1:0] neg_o
);

`ifdef CHANNEL_VECTORS_ROTATE_EN
  assign im_o  = WIDTH'(rotr(IM_TABLE[0],        32'(row_i)));
  assign pos_o = WIDTH'(rotr(PROJM_POS_TABLE[0], 32'(row_i)));
  assign neg_o = WIDTH'(rotr(PROJM_NEG_TABLE[0], 32'(row_i)));
`else
  assign im_o  = WIDTH'(IM_TABLE[row_i]);
  assign pos_o = WIDTH'(PROJM_POS_TABLE[row_i]);
  assign neg_o = WIDTH'(PROJM_NEG_TABLE[row_i]);
`endif

endmodule

// File: rtl/channel_vector_sequencer.sv
// -----------------------------------------------------------------------------
// channel_vector_sequencer
// On Start, sweeps NUM_CHANNELS steps and, for each of NUM_MODS modalities,
// presents the iM / projM_pos / projM_neg vectors of row
// (base_m + step) mod NUM_CHANNELS on a registered valid/ready stream.
// Build option CHANNEL_VECTORS_ROTATE_EN selects seed rotation instead of
// table lookup (see channel_vector_row_select); timing is identical.
// Ports:
//   Clk_CI, Reset_RBI           clock, asynchronous active-low reset
//   Start_SI                    start a sweep (IDLE only)
//   Clear_SI                    synchronous abort to IDLE, highest priority
//   ChannelBase_DI              per-modality start channel, slice m*CH_W
//   Ready_SI                    downstream ready
//   Valid_SO, Last_SO           beat valid, final beat marker
//   Channel_DO                  sweep step of the current beat
//   CellValueOut_DO             iM vectors, slice m*WIDTH
//   projM_pos_DO, projM_neg_DO  projection vectors, slice m*WIDTH
//   Busy_SO                     high while sweeping
//   Done_SO                     one-cycle pulse after the last beat transfers
// -----------------------------------------------------------------------------
module channel_vector_sequencer
  import channel_vector_sequencer_pkg::*;
#(
  parameter int WIDTH        = HV_DIMENSION,
  parameter int NUM_MODS     = 3,
  parameter int NUM_CHANNELS = INPUT_CHANNELS,
  parameter int CH_W         = ceil_log2(NUM_CHANNELS)
) (
  input  logic                       Clk_CI,
  input  logic                       Reset_RBI,
  input  logic                       Start_SI,
  input  logic                       Clear_SI,
  input  logic [NUM_MODS*CH_W-1:0]   ChannelBase_DI,
  input  logic                       Ready_SI,
  output logic                       Valid_SO,
  output logic                       Last_SO,
  output logic [CH_W-1:0]            Channel_DO,
  output logic [NUM_MODS*WIDTH-1:0]  CellValueOut_DO,
  output logic [NUM_MODS*WIDTH-1:0]  projM_pos_DO,
  output logic [NUM_MODS*WIDTH-1:0]  projM_neg_DO,
  output logic                       Busy_SO,
  output logic                       Done_SO
);

  localparam logic [CH_W:0]   N_EXT     = (CH_W+1)'(NUM_CHANNELS);
  localparam logic [CH_W-1:0] LAST_STEP = CH_W'(NUM_CHANNELS - 1);

  state_e                      state_q, state_d;
  logic [CH_W-1:0]             step_q, step_d;
  logic [NUM_MODS*CH_W-1:0]    base_q, base_d;
  logic                        done_q, done_d;
  logic [NUM_MODS*WIDTH-1:0]   im_q, im_d, pos_q, pos_d, neg_q, neg_d;

  logic                        load;
  logic [NUM_MODS*CH_W-1:0]    base_in_red;
  logic [NUM_MODS*CH_W-1:0]    sel_base;
  logic [CH_W-1:0]             sel_step;
  logic [NUM_MODS*WIDTH-1:0]   im_sel, pos_sel, neg_sel;

  // In IDLE the registers are loaded for step 0 from the incoming bases;
  // in RUN they are loaded for the following step from the latched bases.
  assign sel_base = (state_q == IDLE) ? base_in_red : base_q;
  assign sel_step = (state_q == IDLE) ? '0 : CH_W'(step_q + 1'b1);

  for (genvar m = 0; m < NUM_MODS; m++) begin : g_mod
    logic [CH_W:0]   in_ext;
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] row;

    // Bases are reduced once on entry so that base + step < 2*NUM_CHANNELS
    // and one conditional subtraction completes the wrap.
    assign in_ext = {1'b0, ChannelBase_DI[m*CH_W +: CH_W]};
    assign base_in_red[m*CH_W +: CH_W] =
      (in_ext >= N_EXT) ? CH_W'(in_ext - N_EXT) : in_ext[CH_W-1:0];

    assign sum = {1'b0, sel_base[m*CH_W +: CH_W]} + {1'b0, sel_step};
    assign row = (sum >= N_EXT) ? CH_W'(sum - N_EXT) : sum[CH_W-1:0];

    channel_vector_row_select #(
      .WIDTH (WIDTH),
      .CH_W  (CH_W)
    ) u_row_select (
      .row_i (row),
      .im_o  (im_sel[m*WIDTH +: WIDTH]),
      .pos_o (pos_sel[m*WIDTH +: WIDTH]),
      .neg_o (neg_sel[m*WIDTH +: WIDTH])
    );
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    base_d  = base_q;
    done_d  = 1'b0;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start_SI) begin
          state_d = RUN;
          step_d  = '0;
          base_d  = base_in_red;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (Ready_SI) begin
          if (step_q == LAST_STEP) begin
            state_d = IDLE;
            step_d  = '0;
            done_d  = 1'b1;
          end else begin
            step_d = CH_W'(step_q + 1'b1);
            load   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything; vector registers keep their contents.
    if (Clear_SI) begin
      state_d = IDLE;
      step_d  = '0;
      base_d  = base_q;
      done_d  = 1'b0;
      load    = 1'b0;
    end

    im_d  = load ? im_sel  : im_q;
    pos_d = load ? pos_sel : pos_q;
    neg_d = load ? neg_sel : neg_q;
  end

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      state_q <= IDLE;
      step_q  <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
      im_q    <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      base_q  <= base_d;
      done_q  <= done_d;
      im_q    <= im_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
    end
  end

  assign Valid_SO        = (state_q == RUN);
  assign Busy_SO         = (state_q == RUN);
  assign Last_SO         = (state_q == RUN) && (step_q == LAST_STEP);
  assign Channel_DO      = step_q;
  assign Done_SO         = done_q;
  assign CellValueOut_DO = im_q;
  assign projM_pos_DO    = pos_q;
  assign projM_neg_DO    = neg_q;

endmodule
